gbd_ram_write_sched: RTL and testbench

- Sequences GBD-side write jobs into the shared cart SRAM and arbitrates that SRAM against the cartridge bus.
- Accepts a job (base address, length) and a byte stream, then waits for the cart bus to go idle.
- Takes ownership through is_gbd_writing_ram and generates setup/strobe/hold write cycles on the in_Writing_* inputs of the cart RAM mapper.
- Returns ownership to the cart between bytes, so a cart access is never blocked for more than one write cycle.

---
 rtl/gbd_ram_pkg.sv | 24 ++
 rtl/gbd_ram_write_sched_idle_det.sv | 73 +++++++
 rtl/gbd_ram_write_sched.sv | 219 +++++++++++++++++++++
 tb/tb_gbd_ram_write_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbd_ram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : gbd_ram_pkg
// Brief   : Shared types and default widths for the GBD cart-SRAM write
//           scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package gbd_ram_pkg;

  localparam int GBD_ADDR_W = 12;
  localparam int GBD_LEN_W  = 13;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SETUP   = 3'd2,
    S_STROBE  = 3'd3,
    S_HOLD    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gbd_ram_write_sched_idle_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : gbd_bus_idle_det
// Brief   : Two-flop synchroniser for the cart bus strobes plus a saturating
//           counter of consecutive idle cycles.
//           GBD_WR_PREEMPT_STATS_EN exposes the synchronised idle level.
// Rev     : 1.0  initial release
// ============================================================================
module gbd_bus_idle_det
  import gbd_ram_pkg::*;
#(
  parameter int IDLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cart_ncs_i,
  input  logic cart_nrd_i,
  input  logic cart_nwr_i,
  input  logic clear_i,
`ifdef GBD_WR_PREEMPT_STATS_EN
  output logic cart_idle_o,
`endif
  output logic idle_ok_o
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cart_idle;

  // Resynchronise the asynchronous cart strobes into the system clock domain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= {cart_ncs_i, cart_nrd_i, cart_nwr_i};
      sync2_q <= sync1_q;
    end
  end

  assign cart_idle = &sync2_q;

  // Count consecutive idle cycles, saturating; any activity or clear restarts
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !cart_idle) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(IDLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idle_ok_o = (cnt_q == CNT_W'(IDLE_CYCLES));
`ifdef GBD_WR_PREEMPT_STATS_EN
  assign cart_idle_o = cart_idle;
`endif

endmodule
`default_nettype wire

// File: rtl/gbd_ram_write_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : gbd_ram_write_sched
// Brief   : Schedules GBD-side byte writes into the shared cart SRAM, taking
//           ownership only while the cart bus has been idle and handing it
//           back between bytes.
//           GBD_WR_PREEMPT_STATS_EN adds stat_preempt / stat_wait counters.
// Rev     : 1.0  initial release
// ============================================================================
module gbd_ram_write_sched
  import gbd_ram_pkg::*;
#(
  parameter int IDLE_CYCLES = 4,
  parameter int WE_CYCLES   = 2,
  parameter int ADDR_W      = GBD_ADDR_W
) (
  input  logic              sys_clock,
  input  logic              sys_reset,
  input  logic              Cart_nCS,
  input  logic              Cart_nRD,
  input  logic              Cart_nWR,
  input  logic              job_start,
  input  logic [ADDR_W-1:0] job_base,
  input  logic [ADDR_W:0]   job_len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              is_gbd_writing_ram,
  output logic [7:0]        out_Writing_dq,
  output logic [ADDR_W-1:0] out_Writing_Addr_low,
  output logic              out_Writing_nCS,
  output logic              out_Writing_nWE,
  output logic              busy,
`ifdef GBD_WR_PREEMPT_STATS_EN
  output logic [15:0]       stat_preempt,
  output logic [15:0]       stat_wait,
`endif
  output logic              job_done
);

  localparam int         LEN_W   = ADDR_W + 1;
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              own_q;
  logic              ncs_q;
  logic              nwe_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [7:0]        dq_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  acc_q;
  logic [3:0]        we_cnt_q;
  logic              full_q;
  logic [7:0]        hold_q;

  logic              idle_ok;
  logic              accept;
  logic              start_ok;
`ifdef GBD_WR_PREEMPT_STATS_EN
  logic              cart_idle;
  logic [15:0]       preempt_q;
  logic [15:0]       wait_q;
`endif

  // Idle counter restarts in RELEASE so every byte waits a full idle window
  gbd_bus_idle_det #(
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_idle_det (
    .clk_i      (sys_clock),
    .rst_i      (sys_reset),
    .cart_ncs_i (Cart_nCS),
    .cart_nrd_i (Cart_nRD),
    .cart_nwr_i (Cart_nWR),
    .clear_i    (state_q == S_RELEASE),
`ifdef GBD_WR_PREEMPT_STATS_EN
    .cart_idle_o(cart_idle),
`endif
    .idle_ok_o  (idle_ok)
  );

  assign start_ok = (state_q == S_IDLE) && job_start;
  assign s_ready  = busy_q && !full_q && (acc_q < len_q);
  assign accept   = s_valid && s_ready;

  // Single-byte holding register and count of bytes taken for this job
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      full_q <= 1'b0;
      hold_q <= 8'h00;
      acc_q  <= '0;
    end else begin
      if (start_ok) begin
        acc_q <= '0;
      end
      if (accept) begin
        full_q <= 1'b1;
        hold_q <= s_data;
        acc_q  <= acc_q + 1'b1;
      end else if (state_q == S_HOLD) begin
        full_q <= 1'b0;
      end
    end
  end

  // Write-cycle sequencer with all SRAM-side outputs registered
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      own_q      <= 1'b0;
      ncs_q      <= 1'b1;
      nwe_q      <= 1'b1;
      addr_out_q <= '0;
      dq_q       <= 8'h00;
      addr_cnt_q <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      we_cnt_q   <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (job_start) begin
            if (job_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_cnt_q <= job_base;
              rem_q      <= job_len;
              len_q      <= job_len;
              busy_q     <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (full_q && idle_ok) begin
            own_q      <= 1'b1;
            ncs_q      <= 1'b0;
            nwe_q      <= 1'b1;
            addr_out_q <= addr_cnt_q;
            dq_q       <= hold_q;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          nwe_q    <= 1'b0;
          we_cnt_q <= 4'd0;
          state_q  <= S_STROBE;
        end
        S_STROBE: begin
          if (we_cnt_q == WE_LAST) begin
            nwe_q   <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            we_cnt_q <= we_cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          own_q      <= 1'b0;
          ncs_q      <= 1'b1;
          addr_cnt_q <= addr_cnt_q + 1'b1;
          rem_q      <= rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GBD_WR_PREEMPT_STATS_EN
  // Saturating counters of cart contention while owned and of idle waits
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      preempt_q <= 16'h0000;
      wait_q    <= 16'h0000;
    end else if (start_ok) begin
      preempt_q <= 16'h0000;
      wait_q    <= 16'h0000;
    end else begin
      if (own_q && !cart_idle && (preempt_q != 16'hFFFF)) begin
        preempt_q <= preempt_q + 16'd1;
      end
      if ((state_q == S_FETCH) && full_q && !idle_ok && (wait_q != 16'hFFFF)) begin
        wait_q <= wait_q + 16'd1;
      end
    end
  end

  assign stat_preempt = preempt_q;
  assign stat_wait    = wait_q;
`endif

  assign is_gbd_writing_ram   = own_q;
  assign out_Writing_dq       = dq_q;
  assign out_Writing_Addr_low = addr_out_q;
  assign out_Writing_nCS      = ncs_q;
  assign out_Writing_nWE      = nwe_q;
  assign busy                 = busy_q;
  assign job_done             = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gbd_ram_write_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_gbd_ram_write_sched
// Brief   : Directed self-checking bench for gbd_ram_write_sched.
// Rev     : 1.0  initial release
// ============================================================================
module tb_gbd_ram_write_sched;

  logic        sys_clock = 1'b0;
  logic        sys_reset = 1'b1;
  logic        Cart_nCS  = 1'b1;
  logic        Cart_nRD  = 1'b1;
  logic        Cart_nWR  = 1'b1;
  logic        job_start = 1'b0;
  logic [11:0] job_base  = 12'h000;
  logic [12:0] job_len   = 13'd0;
  logic        s_valid   = 1'b0;
  logic [7:0]  s_data    = 8'h00;
  logic        s_ready;
  logic        is_gbd_writing_ram;
  logic [7:0]  out_Writing_dq;
  logic [11:0] out_Writing_Addr_low;
  logic        out_Writing_nCS;
  logic        out_Writing_nWE;
  logic        busy;
  logic        job_done;
`ifdef GBD_WR_PREEMPT_STATS_EN
  logic [15:0] stat_preempt;
  logic [15:0] stat_wait;
`endif

  gbd_ram_write_sched dut (
    .sys_clock            (sys_clock),
    .sys_reset            (sys_reset),
    .Cart_nCS             (Cart_nCS),
    .Cart_nRD             (Cart_nRD),
    .Cart_nWR             (Cart_nWR),
    .job_start            (job_start),
    .job_base             (job_base),
    .job_len              (job_len),
    .s_valid              (s_valid),
    .s_data               (s_data),
    .s_ready              (s_ready),
    .is_gbd_writing_ram   (is_gbd_writing_ram),
    .out_Writing_dq       (out_Writing_dq),
    .out_Writing_Addr_low (out_Writing_Addr_low),
    .out_Writing_nCS      (out_Writing_nCS),
    .out_Writing_nWE      (out_Writing_nWE),
    .busy                 (busy),
`ifdef GBD_WR_PREEMPT_STATS_EN
    .stat_preempt         (stat_preempt),
    .stat_wait            (stat_wait),
`endif
    .job_done             (job_done)
  );

  always #5 sys_clock = ~sys_clock;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- write-cycle monitor (samples on falling edge) ----------
  logic [11:0] rec_addr [64];
  logic [7:0]  rec_dq   [64];
  int          rec_ncs  [64];
  int          rec_nwe  [64];
  int          rec_gap  [64];
  int          n_wr     = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          own_cnt  = 0;
  int          ncs_run  = 0;
  int          nwe_run  = 0;
  int          gap_run  = 0;
  int          last_gap = 0;
  logic        own_prev = 1'b0;
  logic [11:0] cur_addr = 12'h000;
  logic [7:0]  cur_dq   = 8'h00;

  always @(negedge sys_clock) begin
    if (sys_reset) begin
      ncs_run  = 0;
      nwe_run  = 0;
      own_prev = 1'b0;
    end else begin
      if (!out_Writing_nCS) begin
        ncs_run = ncs_run + 1;
        if (!out_Writing_nWE) begin
          nwe_run  = nwe_run + 1;
          cur_addr = out_Writing_Addr_low;
          cur_dq   = out_Writing_dq;
        end
      end else if (ncs_run > 0) begin
        if (n_wr < 64) begin
          rec_addr[n_wr] = cur_addr;
          rec_dq[n_wr]   = cur_dq;
          rec_ncs[n_wr]  = ncs_run;
          rec_nwe[n_wr]  = nwe_run;
          rec_gap[n_wr]  = last_gap;
          n_wr = n_wr + 1;
        end
        ncs_run = 0;
        nwe_run = 0;
      end
      if (is_gbd_writing_ram) begin
        own_cnt = own_cnt + 1;
        if (!own_prev) last_gap = gap_run;
        gap_run = 0;
      end else begin
        gap_run = gap_run + 1;
      end
      own_prev = is_gbd_writing_ram;
      if (job_done) done_cnt = done_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_checks = n_checks + 1;
    if (act < lim) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
    end
  endtask

  task automatic tick();
    @(negedge sys_clock);
    #1;
  endtask

  task automatic start_job(input logic [11:0] b, input logic [12:0] l);
    job_start = 1'b1;
    job_base  = b;
    job_len   = l;
    tick();
    job_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int k;
    s_valid = 1'b1;
    s_data  = d;
    for (k = 0; k < 400; k++) begin
      if (s_ready) break;
      tick();
    end
    if (k == 400) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL send_byte timeout: s_ready=%0b, expected 1", s_ready);
    end else begin
      @(posedge sys_clock);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int done0);
    int k;
    for (k = 0; k < 400; k++) begin
      if (done_cnt != done0) break;
      tick();
    end
    if (k == 400) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL wait_done timeout: done pulses %0d, expected 1", done_cnt - done0);
    end
  endtask

  task automatic wait_nwe_low();
    int k;
    for (k = 0; k < 400; k++) begin
      if (!out_Writing_nWE) break;
      tick();
    end
    if (k == 400) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL wait_nwe_low timeout: nWE=%0b, expected 0", out_Writing_nWE);
    end
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct packed {
    logic [11:0]     base;
    logic [12:0]     len;
    logic [2:0][7:0] data;
  } job_vec_t;

  job_vec_t vecs [5];

  task automatic run_vec(input job_vec_t v);
    int          wr0;
    int          done0;
    logic [11:0] exp_a;
    wr0   = n_wr;
    done0 = done_cnt;
    start_job(v.base, v.len);
    for (int i = 0; i < int'(v.len); i++) send_byte(v.data[i]);
    wait_done(done0);
    repeat (3) tick();
    check("write_count", n_wr - wr0, v.len);
    check("done_pulses", done_cnt - done0, 1);
    check("busy_after", busy, 1'b0);
    exp_a = v.base;
    for (int i = 0; i < int'(v.len); i++) begin
      if (wr0 + i < n_wr) begin
        check("wr_addr", rec_addr[wr0+i], exp_a);
        check("wr_dq", rec_dq[wr0+i], v.data[i]);
        check("wr_ncs_len", rec_ncs[wr0+i], 4);
        check("wr_nwe_len", rec_nwe[wr0+i], 2);
        if (i > 0) check_ge("wr_gap", rec_gap[wr0+i], 5);
      end
      exp_a = exp_a + 12'd1;
    end
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    int wr0;
    int done0;
    int busy0;
    int own0;
    int k;
    job_vec_t v;

    vecs[0] = '{base: 12'h010, len: 13'd3, data: {8'hCC, 8'hBB, 8'hAA}};
    vecs[1] = '{base: 12'hFFF, len: 13'd2, data: {8'h00, 8'h22, 8'h11}};
    vecs[2] = '{base: 12'h123, len: 13'd1, data: {8'h00, 8'h00, 8'h5A}};
    vecs[3] = '{base: 12'h7FE, len: 13'd3, data: {8'hFF, 8'h80, 8'h01}};
    vecs[4] = '{base: 12'h500, len: 13'd2, data: {8'h00, 8'h34, 8'h12}};

    // Reset values
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_own", is_gbd_writing_ram, 1'b0);
    check("rst_dq", out_Writing_dq, 8'h00);
    check("rst_addr", out_Writing_Addr_low, 12'h000);
    check("rst_ncs", out_Writing_nCS, 1'b1);
    check("rst_nwe", out_Writing_nWE, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", job_done, 1'b0);
    sys_reset = 1'b0;
    repeat (8) tick();

    // Table-driven jobs (includes the 0xFFF -> 0x000 wrap)
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Zero-length job: immediate done, never busy, no strobes
    wr0   = n_wr;
    done0 = done_cnt;
    busy0 = busy_cnt;
    start_job(12'h055, 13'd0);
    check("len0_done", job_done, 1'b1);
    check("len0_busy", busy, 1'b0);
    tick();
    check("len0_done_pulse", job_done, 1'b0);
    repeat (10) tick();
    check("len0_no_write", n_wr - wr0, 0);
    check("len0_busy_never", busy_cnt - busy0, 0);
    check("len0_done_once", done_cnt - done0, 1);

    // Cart read active before the byte; ignored job_start while busy
    Cart_nRD = 1'b0;
    repeat (4) tick();
    wr0   = n_wr;
    done0 = done_cnt;
    own0  = own_cnt;
    start_job(12'h200, 13'd1);
    send_byte(8'h77);
    start_job(12'hABC, 13'd5);
    repeat (12) tick();
    check("nrd_no_own", own_cnt - own0, 0);
    Cart_nRD = 1'b1;
    for (k = 0; k < 30; k++) begin
      tick();
      if (is_gbd_writing_ram) break;
    end
    check("nrd_own_delay", k + 1, 7);
    wait_done(done0);
    repeat (3) tick();
    check("nrd_write_count", n_wr - wr0, 1);
    if (n_wr > wr0) begin
      check("nrd_addr", rec_addr[wr0], 12'h200);
      check("nrd_dq", rec_dq[wr0], 8'h77);
    end
    check("nrd_busy_after", busy, 1'b0);

    // Cart chip select falls mid-strobe
    wr0   = n_wr;
    done0 = done_cnt;
    start_job(12'h300, 13'd2);
    send_byte(8'h5C);
    wait_nwe_low();
    Cart_nCS = 1'b0;
    own0 = own_cnt;
    repeat (10) tick();
    check("ncs_own_finish", own_cnt - own0, 2);
`ifdef GBD_WR_PREEMPT_STATS_EN
    check_ge("stat_preempt", int'(stat_preempt), 1);
`endif
    Cart_nCS = 1'b1;
    send_byte(8'hC5);
`ifdef GBD_WR_PREEMPT_STATS_EN
    check_ge("stat_wait", int'(stat_wait), 1);
`endif
    wait_done(done0);
    repeat (3) tick();
    check("ncs_write_count", n_wr - wr0, 2);
    if (n_wr > wr0 + 1) begin
      check("ncs_addr0", rec_addr[wr0], 12'h300);
      check("ncs_dq0", rec_dq[wr0], 8'h5C);
      check("ncs_nwe0", rec_nwe[wr0], 2);
      check("ncs_ncs0", rec_ncs[wr0], 4);
      check("ncs_addr1", rec_addr[wr0+1], 12'h301);
      check("ncs_dq1", rec_dq[wr0+1], 8'hC5);
      check_ge("ncs_gap1", rec_gap[wr0+1], 14);
    end

    // Reset during STROBE: outputs drop without a clock edge
    start_job(12'h400, 13'd2);
    send_byte(8'h99);
    wait_nwe_low();
    wr0 = n_wr;
    #1;
    sys_reset = 1'b1;
    #1;
    check("arst_nwe", out_Writing_nWE, 1'b1);
    check("arst_ncs", out_Writing_nCS, 1'b1);
    check("arst_own", is_gbd_writing_ram, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_s_ready", s_ready, 1'b0);
    repeat (2) tick();
    sys_reset = 1'b0;
    tick();
    check("arst_no_record", n_wr - wr0, 0);
    v = vecs[4];
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
